// File: rtl/hazard_pkg.sv
// Shared types and constants for the load-use hazard / pipeline-control unit.
// Optional statistics counters are built in when HAZARD_STATS_EN is defined.
package hazard_pkg;

  localparam int unsigned REG_W_DEF    = 5;
  localparam int unsigned LOAD_LAT_MAX = 4;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hz_state_t;

  typedef logic [REG_W_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard unit signal bundle; the pipeline is master, hazard_ctrl is slave.
// The stall/flush statistics outputs exist only when HAZARD_STATS_EN is defined.
interface hazard_ctrl_if #(
  parameter int unsigned REG_W = 5
);

  logic             id_ex_mem_read;
  logic [REG_W-1:0] id_ex_rd;
  logic [REG_W-1:0] if_id_rs;
  logic [REG_W-1:0] if_id_rt;
  logic             if_id_uses_rs;
  logic             if_id_uses_rt;
  logic             branch_taken;
  logic             mem_wait;

  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             ctrl_normal;
  logic             pipe_hold;
`ifdef HAZARD_STATS_EN
  logic [31:0]      stall_cycles;
  logic [31:0]      flush_count;
`endif

  modport master (
    output id_ex_mem_read, id_ex_rd, if_id_rs, if_id_rt,
    output if_id_uses_rs, if_id_uses_rt, branch_taken, mem_wait,
`ifdef HAZARD_STATS_EN
    input  stall_cycles, flush_count,
`endif
    input  pc_write, if_id_write, if_id_flush, ctrl_normal, pipe_hold
  );

  modport slave (
    input  id_ex_mem_read, id_ex_rd, if_id_rs, if_id_rt,
    input  if_id_uses_rs, if_id_uses_rt, branch_taken, mem_wait,
`ifdef HAZARD_STATS_EN
    output stall_cycles, flush_count,
`endif
    output pc_write, if_id_write, if_id_flush, ctrl_normal, pipe_hold
  );

endinterface

// File: rtl/hazard_cmp.sv
// Combinational load-use compare: r0 never matches and each source is gated by its uses flag.
// Kept standalone so the forwarding unit can reuse the same qualification.
module hazard_cmp #(
  parameter int unsigned REG_W = 5
) (
  input  logic             mem_read,
  input  logic [REG_W-1:0] rd,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic             uses_rs,
  input  logic             uses_rt,
  output logic             hit_c
);

  logic rs_match_c;
  logic rt_match_c;

  assign rs_match_c = uses_rs && (rd == rs);
  assign rt_match_c = uses_rt && (rd == rt);
  assign hit_c      = mem_read && (rd != '0) && (rs_match_c || rt_match_c);

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use hazard FSM with branch flush and memory-wait freeze for the 5-stage pipeline.
// Define HAZARD_STATS_EN to add saturating stall_cycles / flush_count counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W    = REG_W_DEF,
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  hazard_ctrl_if.slave hz
);

  localparam int unsigned CNT_W = $clog2(LOAD_LAT + 1);

  hz_state_t        state;
  hz_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  logic detect_c;
  logic pc_write_c;
  logic if_id_write_c;
  logic if_id_flush_c;
  logic ctrl_normal_c;
  logic pipe_hold_c;

  hazard_cmp #(
    .REG_W (REG_W)
  ) u_cmp (
    .mem_read (hz.id_ex_mem_read),
    .rd       (hz.id_ex_rd),
    .rs       (hz.if_id_rs),
    .rt       (hz.if_id_rt),
    .uses_rs  (hz.if_id_uses_rs),
    .uses_rt  (hz.if_id_uses_rt),
    .hit_c    (detect_c)
  );

  // State and remaining-bubble counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Priority: mem_wait > branch_taken > ongoing stall / new detect > idle
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    pc_write_c    = 1'b1;
    if_id_write_c = 1'b1;
    if_id_flush_c = 1'b0;
    ctrl_normal_c = 1'b1;
    pipe_hold_c   = 1'b0;

    if (hz.mem_wait) begin
      pc_write_c    = 1'b0;
      if_id_write_c = 1'b0;
      pipe_hold_c   = 1'b1;
    end else if (hz.branch_taken) begin
      // The stalled instruction is on the wrong path, so drop any pending stall
      if_id_flush_c = 1'b1;
      ctrl_normal_c = 1'b0;
      state_nxt     = RUN;
      cnt_nxt       = '0;
    end else if (state == STALL) begin
      pc_write_c    = 1'b0;
      if_id_write_c = 1'b0;
      ctrl_normal_c = 1'b0;
      cnt_nxt       = cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        state_nxt = RUN;
      end
    end else if (detect_c) begin
      pc_write_c    = 1'b0;
      if_id_write_c = 1'b0;
      ctrl_normal_c = 1'b0;
      if (LOAD_LAT > 1) begin
        state_nxt = STALL;
        cnt_nxt   = CNT_W'(LOAD_LAT - 1);
      end
    end
  end

  assign hz.pc_write    = pc_write_c;
  assign hz.if_id_write = if_id_write_c;
  assign hz.if_id_flush = if_id_flush_c;
  assign hz.ctrl_normal = ctrl_normal_c;
  assign hz.pipe_hold   = pipe_hold_c;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;

  // Bubble and flush counters; a mem_wait cycle has ctrl_normal=1 so it is never counted
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!ctrl_normal_c && !if_id_flush_c && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (if_id_flush_c && (flush_count != '1)) begin
        flush_count <= flush_count + 32'd1;
      end
    end
  end

  assign hz.stall_cycles = stall_cycles;
  assign hz.flush_count  = flush_count;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: four instances (LOAD_LAT 1..4) share one stimulus stream,
// checked against a directed table and a bubble-count reference model.
module tb_hazard_ctrl;

  localparam logic [4:0] IDLE = 5'b11010; // {pc_write, if_id_write, if_id_flush, ctrl_normal, pipe_hold}
  localparam logic [4:0] BUB  = 5'b00000;
  localparam logic [4:0] WAIT = 5'b00011;
  localparam logic [4:0] FLU  = 5'b11100;

  typedef struct {
    logic       rst;
    logic       mr;
    logic [4:0] rd;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       br;
    logic       mw;
    logic [4:0] e3;
    logic [4:0] e1;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       mr;
  logic [4:0] rd, rs, rt;
  logic       urs, urt, br, mw;

  logic [4:0]  outs [4];
`ifdef HAZARD_STATS_EN
  logic [31:0] st [4];
  logic [31:0] fl [4];
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rem [4];
  int sc  [4];
  int fc  [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gen_dut
    hazard_ctrl_if #(.REG_W(5)) hz ();
    assign hz.id_ex_mem_read = mr;
    assign hz.id_ex_rd       = rd;
    assign hz.if_id_rs       = rs;
    assign hz.if_id_rt       = rt;
    assign hz.if_id_uses_rs  = urs;
    assign hz.if_id_uses_rt  = urt;
    assign hz.branch_taken   = br;
    assign hz.mem_wait       = mw;
    hazard_ctrl #(.REG_W(5), .LOAD_LAT(g + 1)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
    );
    assign outs[g] = {hz.pc_write, hz.if_id_write, hz.if_id_flush, hz.ctrl_normal, hz.pipe_hold};
`ifdef HAZARD_STATS_EN
    assign st[g] = hz.stall_cycles;
    assign fl[g] = hz.flush_count;
`endif
  end

  function automatic vec_t mk(input logic r, input logic m, input int d, input int s, input int t,
                              input logic us, input logic ut, input logic b, input logic w,
                              input logic [4:0] x3, input logic [4:0] x1);
    vec_t v;
    v.rst = r; v.mr = m; v.rd = 5'(d); v.rs = 5'(s); v.rt = 5'(t);
    v.urs = us; v.urt = ut; v.br = b; v.mw = w; v.e3 = x3; v.e1 = x1;
    return v;
  endfunction

  function automatic logic det();
    return mr && (rd != 5'd0) && ((urs && (rd == rs)) || (urt && (rd == rt)));
  endfunction

  // Reference: remaining bubble count per instance, not a state machine
  function automatic logic [4:0] model_out(input int k);
    if (mw) return WAIT;
    if (br) return FLU;
    if (rem[k] > 0 || det()) return BUB;
    return IDLE;
  endfunction

  task automatic model_step();
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        rem[k] = 0; sc[k] = 0; fc[k] = 0;
      end else if (mw) begin
        rem[k] = rem[k];
      end else if (br) begin
        rem[k] = 0; fc[k]++;
      end else if (rem[k] > 0) begin
        rem[k]--; sc[k]++;
      end else if (det()) begin
        rem[k] = k; sc[k]++;
      end
    end
  endtask

  task automatic check5(input string name, input int k, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s L=%0d cycle=%0d got=%b exp=%b", name, k + 1, cyc, got, exp);
    end
  endtask

  task automatic check32(input string name, input int k, input logic [31:0] got, input int exp);
    checks++;
    if (got !== 32'(exp)) begin
      errors++;
      $display("FAIL %s L=%0d cycle=%0d got=%0d exp=%0d", name, k + 1, cyc, got, exp);
    end
  endtask

  task automatic cycle(input vec_t v, input bit use_tbl);
    rst = v.rst; mr = v.mr; rd = v.rd; rs = v.rs; rt = v.rt;
    urs = v.urs; urt = v.urt; br = v.br; mw = v.mw;
    @(negedge clk);
    for (int k = 0; k < 4; k++) check5("model_out", k, outs[k], model_out(k));
    if (use_tbl) begin
      check5("tbl_out", 2, outs[2], v.e3);
      check5("tbl_out", 0, outs[0], v.e1);
    end
`ifdef HAZARD_STATS_EN
    for (int k = 0; k < 4; k++) begin
      check32("stall_cycles", k, st[k], sc[k]);
      check32("flush_count", k, fl[k], fc[k]);
    end
`endif
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  vec_t tbl [$];
  vec_t nop;
  vec_t lu;

  initial begin
    rst = 1'b1; mr = 1'b0; rd = '0; rs = '0; rt = '0;
    urs = 1'b0; urt = 1'b0; br = 1'b0; mw = 1'b0;
    for (int k = 0; k < 4; k++) begin rem[k] = 0; sc[k] = 0; fc[k] = 0; end
    repeat (2) @(posedge clk);
    #1;

    nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, IDLE);
    lu  = mk(0, 1, 8, 8, 0, 1, 0, 0, 0, BUB, BUB);

    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, IDLE));  // reset state
    tbl.push_back(lu);                                           // plain stall
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, BUB, IDLE));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, BUB, IDLE));
    tbl.push_back(nop);
    tbl.push_back(lu);                                           // stall with 2 wait cycles
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, WAIT, WAIT));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, WAIT, WAIT));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, BUB, IDLE));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, BUB, IDLE));
    tbl.push_back(nop);
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, IDLE, IDLE));  // r0 never stalls
    tbl.push_back(mk(0, 1, 9, 3, 9, 1, 0, 0, 0, IDLE, IDLE));  // rt masked by uses flag
    tbl.push_back(lu);                                           // branch in 2nd stall cycle
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, FLU, FLU));
    tbl.push_back(nop);
    tbl.push_back(lu);                                           // reset during stall
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, BUB, IDLE));
    tbl.push_back(nop);
    tbl.push_back(lu);                                           // fresh full stall
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, BUB, IDLE));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, BUB, IDLE));
    tbl.push_back(nop);
    tbl.push_back(mk(0, 1, 5, 0, 5, 0, 1, 0, 0, BUB, BUB));    // rt dependence
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, BUB, IDLE));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, BUB, IDLE));
    tbl.push_back(mk(0, 1, 6, 6, 6, 1, 1, 0, 0, BUB, BUB));    // back-to-back load-use
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, BUB, IDLE));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, BUB, IDLE));
    tbl.push_back(nop);
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, WAIT, WAIT));  // wait masks branch
    tbl.push_back(nop);
    tbl.push_back(mk(0, 1, 8, 8, 0, 1, 0, 0, 1, WAIT, WAIT));  // wait masks detect
    tbl.push_back(lu);
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, BUB, IDLE));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, FLU, FLU));
    tbl.push_back(nop);

    foreach (tbl[i]) cycle(tbl[i], 1'b1);

    // Two load-use pairs and one branch after a reset
    cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, IDLE), 1'b0);
    cycle(lu, 1'b0);
    cycle(nop, 1'b0);
    cycle(lu, 1'b0);
    cycle(nop, 1'b0);
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, FLU, FLU), 1'b0);
    cycle(nop, 1'b0);
    cycle(nop, 1'b0);
`ifdef HAZARD_STATS_EN
    check32("stats_l2_stall", 1, st[1], 4);
    check32("stats_l2_flush", 1, fl[1], 1);
`endif

    // Random traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      vec_t v;
      v = mk(($urandom_range(99) < 2), $urandom_range(1), int'($urandom_range(3)),
             int'($urandom_range(3)), int'($urandom_range(3)), $urandom_range(1),
             $urandom_range(1), ($urandom_range(99) < 10), ($urandom_range(99) < 15),
             IDLE, IDLE);
      cycle(v, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Parametrised load-use hazard and pipeline-control unit for the 5-stage MIPS pipeline. It replaces the purely combinational one-bubble detector with a small FSM. The FSM adds:
- a configurable number of load-use bubbles
- branch-taken flush
- data-memory wait freeze
- per-operand "uses" qualification and r0 exclusion

It sits in ID and drives the PC, IF/ID, ID/EX control-mux and downstream pipeline-register enables.

Parameters:
REG_W, 5, register-address width
LOAD_LAT, 1, bubbles required after a load before a dependent instruction may enter EX; legal 1..4
CNT_W, $clog2(LOAD_LAT+1), stall-counter width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
id_ex_mem_read  in  1  instruction in EX is a load
id_ex_rd  in  REG_W  destination register of the instruction in EX
if_id_rs  in  REG_W  source register 1 of the instruction in ID
if_id_rt  in  REG_W  source register 2 of the instruction in ID
if_id_uses_rs  in  1  ID instruction reads rs
if_id_uses_rt  in  1  ID instruction reads rt
branch_taken  in  1  branch or jump resolved taken in EX
mem_wait  in  1  data memory not ready; whole pipe must hold
pc_write  out  1  PC enable
if_id_write  out  1  IF/ID enable
if_id_flush  out  1  clear IF/ID to NOP
ctrl_normal  out  1  1 = pass ID controls into ID/EX; 0 = inject zero controls (bubble)
pipe_hold  out  1  hold ID/EX, EX/MEM and MEM/WB

Behaviour:
- Clocking and reset: single clock. rst is synchronous, active-high, and has top priority. rst is sampled at the edge.
- Reset/idle output values: pc_write=1, if_id_write=1, if_id_flush=0, ctrl_normal=1, pipe_hold=0. After reset: state=RUN, cnt=0.
- detect = id_ex_mem_read && id_ex_rd!=0 && ((if_id_uses_rs && id_ex_rd==if_id_rs) || (if_id_uses_rt && id_ex_rd==if_id_rt)).
- Outputs are combinational from current state and inputs. There is zero-cycle latency from detect to stall.
- States: RUN, STALL.
- Per-cycle priority: mem_wait > branch_taken > STALL/detect > normal.
- mem_wait=1, any state:
  - Outputs: pc_write=0, if_id_write=0, pipe_hold=1, ctrl_normal=1, if_id_flush=0.
  - State and cnt are frozen; no decrement.
  - branch_taken and detect are ignored this cycle; they are re-evaluated when mem_wait drops.
- branch_taken=1 (no mem_wait):
  - Outputs: if_id_flush=1, ctrl_normal=0, pc_write=1, if_id_write=1.
  - Next state RUN, cnt=0. Any pending stall is cancelled, because the stalled instruction is on the wrong path.
- RUN with detect:
  - Outputs: pc_write=0, if_id_write=0, ctrl_normal=0.
  - If LOAD_LAT>1: next state STALL, cnt=LOAD_LAT-1. Otherwise remain in RUN.
- STALL:
  - Outputs: pc_write=0, if_id_write=0, ctrl_normal=0.
  - cnt decrements each cycle. When cnt==1, next state is RUN.
  - detect is not re-evaluated in STALL, because ID/EX holds a bubble.
- Exactly LOAD_LAT consecutive bubble cycles are produced per load-use pair, excluding mem_wait cycles.
- RUN without detect: idle output values.
- Boundaries:
  - id_ex_rd==0 never stalls.
  - A "uses" flag of 0 masks its compare.
  - Back-to-back dependent loads each produce a full LOAD_LAT stall.
  - rst asserted in STALL returns to RUN/idle on the next edge.

Optional Feature:
HAZARD_STATS_EN.
- Defined: adds outputs stall_cycles[31:0] and flush_count[31:0], both saturating counters, both cleared by rst.
  - stall_cycles increments in every cycle with ctrl_normal=0 and if_id_flush=0.
  - flush_count increments on every cycle with if_id_flush=1.
  - mem_wait cycles are not counted.
- Undefined: these ports and counters are absent; functional behaviour is identical.

Decomposition:
- Package hazard_pkg: state enum hz_state_t {RUN, STALL}, typedef reg_addr_t (logic [REG_W-1:0]), and constant LOAD_LAT_MAX=4.
- One sub-module, hazard_cmp: purely combinational detect logic (r0 exclusion and uses masking), reusable by the forwarding unit.
- FSM, counter and stats counters stay in hazard_ctrl.

Test Plan:
- LOAD_LAT=1: load to r8 in EX, ID uses rs=8 -> one cycle with pc_write=0, if_id_write=0, ctrl_normal=0; normal values the next cycle.
- LOAD_LAT=3: same stimulus -> exactly 3 consecutive bubble cycles. Then, with mem_wait=1 for 2 cycles in the middle -> 5 cycles total, pipe_hold=1 only during the 2 wait cycles.
- Load to r0 with ID rs=0; also load to r9 with ID rt=9 but if_id_uses_rt=0 -> no stall in either case.
- LOAD_LAT=3: branch_taken=1 in the 2nd stall cycle -> if_id_flush=1 and ctrl_normal=0 that cycle, then idle outputs next cycle (stall cancelled).
- rst=1 during STALL -> next cycle shows idle outputs; a fresh load-use then stalls a full LOAD_LAT.
- HAZARD_STATS_EN, LOAD_LAT=2: two load-use pairs plus one branch -> stall_cycles=4, flush_count=1.
